// File: rtl/alu_pkg.sv
// alu_pkg: ALU function codes and the sharing controller state type.
package alu_pkg;
  localparam logic [2:0] ALU_F_AND = 3'b000;
  localparam logic [2:0] ALU_F_OR  = 3'b001;
  localparam logic [2:0] ALU_F_ADD = 3'b010;
  localparam logic [2:0] ALU_F_SUB = 3'b110;
  localparam logic [2:0] ALU_F_SLT = 3'b111;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} alu_share_state_t;
endpackage

// File: rtl/alu.sv
// alu: combinational ALU; SUB/SLT add the inverted b with carry-in 1, flags from that adder.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       f,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             carry_out,
  output logic             overflow
);
  logic [WIDTH-1:0] w_b;
  logic [WIDTH-1:0] w_sum;
  logic             w_cout;
  logic             w_ovf;
  logic             w_arith;
  assign w_b = f[2] ? ~b : b;
  assign {w_cout, w_sum} = {1'b0, a} + {1'b0, w_b} + {{WIDTH{1'b0}}, f[2]};
  assign w_ovf = (a[WIDTH-1] == w_b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
  assign w_arith = f == ALU_F_ADD || f == ALU_F_SUB || f == ALU_F_SLT;
  assign y = f == ALU_F_AND ? a & b :
             f == ALU_F_OR  ? a | b :
             f == ALU_F_ADD || f == ALU_F_SUB ? w_sum :
             f == ALU_F_SLT ? {{(WIDTH-1){1'b0}}, w_sum[WIDTH-1] ^ w_ovf} : '0;
  assign zero = y == '0;
  assign carry_out = w_arith & w_cout;
  assign overflow = w_arith & w_ovf;
endmodule

// File: rtl/alu_share_ctrl_rr_pick2.sv
// rr_pick2: two-way round-robin pick; ptr only breaks ties when both requesters are valid.
module rr_pick2 (
  input  logic [1:0] i_valid,
  input  logic       i_ptr,
  output logic [1:0] o_grant
);
  assign o_grant = &i_valid ? (i_ptr ? 2'b10 : 2'b01) : i_valid;
endmodule

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: shares one ALU between two valid/ready requesters, round-robin,
// with registered operands and a registered result returned to the winning requester.
module alu_share_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_f,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_f,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             resp0_valid,
  input  logic             resp0_ready,
  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic [WIDTH-1:0] resp_y,
  output logic             resp_zero,
  output logic             resp_carry_out,
  output logic             resp_overflow,
  output logic [2:0]       alu_f,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_y,
  input  logic             alu_zero,
  input  logic             alu_carry_out,
  input  logic             alu_overflow
);
  alu_share_state_t r_state;
  logic             r_ptr;
  logic             r_owner;
  logic [1:0]       r_resp_valid;
  logic [2:0]       r_f;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_y;
  logic             r_zero;
  logic             r_carry;
  logic             r_ovf;
  logic [1:0]       w_grant;
  logic             w_resp_ready;
  rr_pick2 u_pick (
    .i_valid({req1_valid, req0_valid}),
    .i_ptr  (r_ptr),
    .o_grant(w_grant)
  );
  assign req0_ready = r_state == IDLE && w_grant[0];
  assign req1_ready = r_state == IDLE && w_grant[1];
  assign w_resp_ready = r_owner ? resp1_ready : resp0_ready;
  assign {resp1_valid, resp0_valid} = r_resp_valid;
  assign resp_y = r_y;
  assign resp_zero = r_zero;
  assign resp_carry_out = r_carry;
  assign resp_overflow = r_ovf;
  assign alu_f = r_f;
  assign alu_a = r_a;
  assign alu_b = r_b;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_ptr <= 1'b0;
      r_owner <= 1'b0;
      r_resp_valid <= '0;
      r_f <= '0;
      r_a <= '0;
      r_b <= '0;
      r_y <= '0;
      r_zero <= 1'b0;
      r_carry <= 1'b0;
      r_ovf <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (|w_grant) begin
          r_f <= w_grant[1] ? req1_f : req0_f;
          r_a <= w_grant[1] ? req1_a : req0_a;
          r_b <= w_grant[1] ? req1_b : req0_b;
          r_owner <= w_grant[1];
          r_state <= EXEC;
        end
        EXEC: begin
          r_y <= alu_y;
          r_zero <= alu_zero;
          r_carry <= alu_carry_out;
          r_ovf <= alu_overflow;
          r_resp_valid <= r_owner ? 2'b10 : 2'b01;
          r_state <= RESP;
        end
        RESP: if (w_resp_ready) begin
          r_resp_valid <= '0;
          r_ptr <= ~r_owner;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb_alu_share_ctrl: directed vectors; accepted requests push expected results, a monitor pops on response handshakes.
module tb_alu_share_ctrl;
  import alu_pkg::*;
  typedef struct {
    int          id;
    logic [31:0] y;
    logic        z, c, o;
    int          acc;
  } exp_t;
  logic clk = 1'b0, reset = 1'b1;
  logic req0_valid = 0, req1_valid = 0, req0_ready, req1_ready;
  logic [2:0] req0_f = '0, req1_f = '0;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic resp0_valid, resp1_valid, resp0_ready = 1'b1, resp1_ready = 1'b1;
  logic [31:0] resp_y, alu_a, alu_b, alu_y;
  logic resp_zero, resp_carry_out, resp_overflow, alu_zero, alu_carry_out, alu_overflow;
  logic [2:0] alu_f;
  exp_t sb[$];
  int tests = 0, fails = 0, cyc = 0;
  bit prev0 = 0, prev1 = 0;

  alu_share_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_f(req0_f), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_f(req1_f), .req1_a(req1_a), .req1_b(req1_b),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
    .resp_y(resp_y), .resp_zero(resp_zero), .resp_carry_out(resp_carry_out), .resp_overflow(resp_overflow),
    .alu_f(alu_f), .alu_a(alu_a), .alu_b(alu_b), .alu_y(alu_y),
    .alu_zero(alu_zero), .alu_carry_out(alu_carry_out), .alu_overflow(alu_overflow)
  );
  alu #(.WIDTH(32)) u_alu (
    .f(alu_f), .a(alu_a), .b(alu_b), .y(alu_y),
    .zero(alu_zero), .carry_out(alu_carry_out), .overflow(alu_overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] y, input logic z, c, o);
    exp_t e;
    e.id = 0; e.y = y; e.z = z; e.c = c; e.o = o; e.acc = 0;
    return e;
  endfunction

  task automatic cycle();
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (reset) begin
      prev0 = 0; prev1 = 0;
    end else begin
      if (resp0_valid && resp1_valid) chk("resp_valid_exclusive", 32'h3, 32'h1);
      for (int ch = 0; ch < 2; ch++) begin
        bit v, r, p;
        v = ch == 0 ? resp0_valid : resp1_valid;
        r = ch == 0 ? resp0_ready : resp1_ready;
        p = ch == 0 ? prev0 : prev1;
        if (v && !p) begin
          if (sb.size() == 0) chk("spurious_resp", 32'(ch), 32'hFFFF);
          else begin
            chk("resp_channel", 32'(ch), 32'(sb[0].id));
            chk("latency", 32'(cyc - sb[0].acc), 32'd2);
          end
        end
        if (v && r && sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          chk("resp_y", resp_y, e.y);
          chk("resp_flags", {29'b0, resp_zero, resp_carry_out, resp_overflow}, {29'b0, e.z, e.c, e.o});
        end
      end
      prev0 = resp0_valid; prev1 = resp1_valid;
    end
  end

  task automatic send(input bit v0, input logic [2:0] f0, input logic [31:0] a0, b0, input exp_t e0,
                      input bit v1, input logic [2:0] f1, input logic [31:0] a1, b1, input exp_t e1,
                      input int first, input bit push);
    bit p0, p1, g0, g1;
    int n;
    req0_valid = v0; req0_f = f0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_f = f1; req1_a = a1; req1_b = b1;
    p0 = v0; p1 = v1; n = 0;
    while ((p0 || p1) && n < 40) begin
      @(negedge clk);
      n++;
      g0 = p0 && req0_ready;
      g1 = p1 && req1_ready;
      if (req0_ready && req1_ready) chk("single_grant", 32'h3, 32'h1);
      if (p0 && p1 && (g0 || g1)) chk("arb_winner", {31'b0, g1}, first);
      if (g0) begin
        e0.id = 0; e0.acc = cyc;
        if (push) sb.push_back(e0);
        p0 = 0;
      end
      if (g1) begin
        e1.id = 1; e1.acc = cyc;
        if (push) sb.push_back(e1);
        p1 = 0;
      end
      cycle();
      if (!p0) req0_valid = 0;
      if (!p1) req1_valid = 0;
    end
    if (p0 || p1) chk("accept_timeout", {30'b0, p1, p0}, 32'h0);
    req0_valid = 0; req1_valid = 0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk); n++;
    end
    chk("drain", sb.size(), 0);
    cycle();
  endtask

  initial begin
    exp_t nx;
    nx = mk(0, 0, 0, 0);
    cycle(); cycle();
    @(negedge clk);
    chk("rst_ready", {30'b0, req1_ready, req0_ready}, 0);
    chk("rst_resp_valid", {30'b0, resp1_valid, resp0_valid}, 0);
    chk("rst_alu", alu_a | alu_b | {29'b0, alu_f}, 0);
    chk("rst_resp", resp_y | {29'b0, resp_zero, resp_carry_out, resp_overflow}, 0);
    cycle();
    reset = 0;
    // test 1: single ADD with carry-out and zero result
    send(1, ALU_F_ADD, 32'h1, 32'hFFFFFFFF, mk(32'h0, 1, 1, 0), 0, 0, 0, 0, nx, 0, 1);
    drain();
    // test 2: contention from a fresh pointer, then both again
    reset = 1; cycle(); reset = 0;
    send(1, ALU_F_SUB, 32'h5, 32'h3, mk(32'h2, 0, 1, 0),
         1, ALU_F_OR, 32'hF0F00000, 32'h0000F0F0, mk(32'hF0F0F0F0, 0, 0, 0), 0, 1);
    drain();
    send(1, ALU_F_SUB, 32'h5, 32'h3, mk(32'h2, 0, 1, 0),
         1, ALU_F_OR, 32'hF0F00000, 32'h0000F0F0, mk(32'hF0F0F0F0, 0, 0, 0), 0, 1);
    drain();
    // test 3: response backpressure on requester 1
    resp1_ready = 0;
    send(0, 0, 0, 0, nx, 1, ALU_F_OR, 32'hF0F00000, 32'h0000F0F0, mk(32'hF0F0F0F0, 0, 0, 0), 1, 1);
    req0_valid = 1; req0_f = ALU_F_ADD; req0_a = 32'h3; req0_b = 32'h4;
    req1_valid = 1;
    for (int n = 0; n < 10 && !resp1_valid; n++) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", {31'b0, resp1_valid}, 1);
      chk("stall_y", resp_y, 32'hF0F0F0F0);
      chk("stall_ready", {30'b0, req1_ready, req0_ready}, 0);
      cycle();
      if (i == 4) begin
        req0_valid = 0; req1_valid = 0; resp1_ready = 1;
      end
      @(negedge clk);
    end
    cycle();
    @(negedge clk);
    chk("stall_release", {31'b0, resp1_valid}, 0);
    drain();
    // test 4: signed overflow and set-less-than
    send(1, ALU_F_SUB, 32'h80000000, 32'h1, mk(32'h7FFFFFFF, 0, 1, 1), 0, 0, 0, 0, nx, 0, 1);
    drain();
    send(1, ALU_F_SLT, 32'hFFFFFFFF, 32'h1, mk(32'h1, 0, 1, 0), 0, 0, 0, 0, nx, 0, 1);
    drain();
    // test 5: reset while an op is executing
    send(1, ALU_F_ADD, 32'h12345678, 32'h11111111, nx, 0, 0, 0, 0, nx, 0, 0);
    chk("exec_alu_a", alu_a, 32'h12345678);
    reset = 1;
    cycle();
    @(negedge clk);
    chk("midrst_ready", {30'b0, req1_ready, req0_ready}, 0);
    chk("midrst_resp_valid", {30'b0, resp1_valid, resp0_valid}, 0);
    chk("midrst_alu", alu_a | alu_b | {29'b0, alu_f}, 0);
    cycle();
    reset = 0;
    repeat (5) cycle();
    send(0, 0, 0, 0, nx, 1, ALU_F_AND, 32'hFF00FF00, 32'h0FF00FF0, mk(32'h0F000F00, 0, 0, 0), 1, 1);
    drain();
    repeat (3) cycle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
